ct_merge_wrr: RTL and testbench
===============================

Name: ct_merge_wrr

Overview:
- Packet-aware N-to-1 stream merge with weighted round-robin arbitration. This is the next-generation streaming merge.
- The grant is locked from the first accepted beat of a packet until its EOP beat is accepted.
- The granted input may send up to i_weight+1 consecutive packets before the grant rotates.
- Sits in front of shared links and NoC egress where inputs need unequal bandwidth shares.

Parameters:
RADIX, 4, number of input channels (>=1); RADBITS = max(1, ceil(log2(RADIX)))
WIDTH, 32, data beat width in bits (includes EOP bit)
EOP_LOC, 0, bit index of EOP within a beat
WBITS, 4, width of each per-input weight

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_data  in  RADIX*WIDTH  input beats; channel g at [g*WIDTH +: WIDTH]
i_valid  in  RADIX  per-input valid
o_ready  out  RADIX  per-input ready
i_weight  in  RADIX*WBITS  per-input weight w; grants w+1 packets per turn
o_data  out  WIDTH  merged beat
o_valid  out  1  merged valid
i_ready  in  1  downstream ready
o_sel  out  RADBITS  index of the currently granted input

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port named reset.
- Registers and reset values: cur=0, state=S_NORMAL, credit=0, exh=1.
- Outputs (combinational from cur):
  - o_sel=cur
  - o_valid=i_valid[cur]
  - o_data=i_data[cur]
  - o_ready[g]=i_ready && (cur==g)
  - In the cycle after reset: o_sel=0, and o_valid/o_data follow input 0.
- Beat transfer: a beat transfers when o_valid && i_ready. eop = o_data[EOP_LOC]. Latency is 0 cycles (pass-through).
- State S_NORMAL (packet boundary):
  - On transfer with !eop: go to S_WAIT_EOP; cur holds.
  - Otherwise, arbitrate each cycle and load the result into cur.
- State S_WAIT_EOP:
  - cur is frozen.
  - On transfer with eop: return to S_NORMAL.
  - Bubbles (i_valid[cur]=0) never release the grant.
- Packet accounting, on every transfer with eop (either state):
  - If credit!=0: credit <= credit-1.
  - Else: exh <= 1.
- Arbitration (S_NORMAL only):
  - hold_ok = i_valid[cur] && !exh && !(eop transfer this cycle && credit==0).
  - If hold_ok: keep cur.
  - Otherwise: round-robin scan starting at cur+1 mod RADIX, wrapping, with cur checked last. The first valid input wins.
  - If no input is valid, cur holds.
- Grant change or re-grant after exhaustion:
  - Applies when the winner differs from cur, or the winner equals cur with exh set.
  - Actions: credit <= i_weight[winner], exh <= 0.
  - Weight is sampled only at grant time. Changes to i_weight mid-turn take effect at the next grant.
- Arbitration latency: a newly winning input sees o_ready one cycle after arbitration selects it.
- Single-beat packets: arbitration and the transfer happen in the same S_NORMAL cycle, with up to 1 packet/cycle throughput.
- Boundary conditions:
  - weight=0 gives pure packet round-robin.
  - A lone requester is re-granted indefinitely, with credit reloaded on each turn.
  - RADIX=1: cur is constant 0 and arbitration is trivial.
- Reset mid-packet: returns to S_NORMAL with cur=0. The truncated packet is not completed; downstream framing recovery is out of scope.
- A simultaneous eop transfer and arbitration in the same cycle uses the post-transfer credit state (hold_ok term above).

Optional Feature:
- Macro: CT_MERGE_WRR_OREG_EN.
- Defined: a 2-entry skid register sits between the arbiter and o_data/o_valid.
  - o_valid/o_data are registered; o_valid resets to 0.
  - Arbiter-side ready = skid not full.
  - Adds +1 cycle latency and keeps full throughput under back-pressure.
  - o_sel still reflects the arbiter grant, not the registered output.
- Undefined: pure combinational pass-through as described above.

Test Plan:
- Reset, then input 2 alone sends a 3-beat packet (eop on beat 3), i_ready=1 -> o_sel=2 from cycle 2; o_data equals the 3 beats in order; o_ready[0,1,3]=0 throughout.
- All 4 inputs send continuous single-beat packets, weights 0 -> o_sel sequence 1,2,3,0,1,... with one packet per grant.
- Weights {0:2, 1:0, 2:0, 3:0}, all inputs saturated with 1-beat packets -> per 6-packet round: input 0 gets 3 packets, inputs 1-3 get 1 each.
- Input 1 sends a 4-beat packet, i_valid[1] deasserts for 2 cycles after beat 2 while input 3 is valid -> grant stays 1, no beat from input 3 until after input 1's eop.
- i_ready held low 5 cycles mid-packet -> no transfer, o_data stable, o_sel unchanged; on release the packet resumes with no beat lost or duplicated.
- Reset asserted during beat 2 of a packet on input 3 -> next cycle state=S_NORMAL, o_sel=0, o_valid=i_valid[0]; with the macro defined, o_valid=0 after reset.

Source files
------------

// File: rtl/ct_merge_wrr.sv
// Packet-aware N-to-1 stream merge with weighted round-robin grant (w+1 packets per turn).
// Optional macro CT_MERGE_WRR_OREG_EN inserts a 2-entry registered skid stage on o_data/o_valid.
module ct_merge_wrr #(
  parameter int RADIX   = 4,
  parameter int WIDTH   = 32,
  parameter int EOP_LOC = 0,
  parameter int WBITS   = 4,
  localparam int RADBITS = (RADIX > 1) ? $clog2(RADIX) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RADIX*WIDTH-1:0] i_data,
  input  logic [RADIX-1:0]       i_valid,
  output logic [RADIX-1:0]       o_ready,
  input  logic [RADIX*WBITS-1:0] i_weight,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [RADBITS-1:0]     o_sel
);

  typedef enum logic [0:0] {S_NORMAL, S_WAIT_EOP} state_t;

  state_t             state;
  logic [RADBITS-1:0] cur;
  logic [RADBITS-1:0] winner;
  logic [WBITS-1:0]   credit;
  logic               exh;
  logic               found;
  logic               arb_ready;
  logic               vld_p0;
  logic [WIDTH-1:0]   data_p0;
  logic               xfer;
  logic               eop_xfer;
  logic               exh_post;
  logic               hold_ok;
  logic               regrant;

  function automatic logic [RADBITS-1:0] rr_idx(input logic [RADBITS-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= RADIX) s = s - RADIX;
    return RADBITS'(s);
  endfunction

  // Stage p0: granted input muxed straight through
  assign vld_p0   = i_valid[cur];
  assign data_p0  = i_data[int'(cur)*WIDTH +: WIDTH];
  assign xfer     = vld_p0 && arb_ready;
  assign eop_xfer = xfer && data_p0[EOP_LOC];
  // Exhaustion as seen after this cycle's eop accounting
  assign exh_post = exh || (eop_xfer && (credit == '0));
  assign hold_ok  = vld_p0 && !exh_post;
  assign o_sel    = cur;

  always_comb begin
    o_ready = '0;
    for (int g = 0; g < RADIX; g++) begin
      o_ready[g] = arb_ready && (int'(cur) == g);
    end
  end

  always_comb begin
    winner = cur;
    found  = 1'b0;
    for (int k = 1; k <= RADIX; k++) begin
      if (!found && i_valid[rr_idx(cur, k)]) begin
        found  = 1'b1;
        winner = rr_idx(cur, k);
      end
    end
  end

  assign regrant = (state == S_NORMAL) && !(xfer && !data_p0[EOP_LOC]) && !hold_ok &&
                   found && ((winner != cur) || exh_post);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= '0;
      state  <= S_NORMAL;
      credit <= '0;
      exh    <= 1'b1;
    end else begin
      case (state)
        S_NORMAL:   if (xfer && !data_p0[EOP_LOC]) state <= S_WAIT_EOP;
        S_WAIT_EOP: if (eop_xfer) state <= S_NORMAL;
        default:    state <= S_NORMAL;
      endcase
      // A new grant reloads the turn and overrides the eop accounting
      if (regrant) begin
        cur    <= winner;
        credit <= i_weight[int'(winner)*WBITS +: WBITS];
        exh    <= 1'b0;
      end else if (eop_xfer) begin
        if (credit != '0) credit <= credit - WBITS'(1);
        else              exh    <= 1'b1;
      end
    end
  end

`ifdef CT_MERGE_WRR_OREG_EN
  logic [WIDTH-1:0] skid0_p1;
  logic [WIDTH-1:0] skid1_p1;
  logic             vld_p1;
  logic             full_p1;
  logic             pop_p1;

  // Stage p1: two-entry skid, head entry drives the outputs
  assign arb_ready = !full_p1;
  assign pop_p1    = vld_p1 && i_ready;
  assign o_valid   = vld_p1;
  assign o_data    = skid0_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      full_p1 <= 1'b0;
    end else if (xfer && !pop_p1) begin
      if (!vld_p1) vld_p1  <= 1'b1;
      else         full_p1 <= 1'b1;
    end else if (pop_p1 && !xfer) begin
      if (full_p1) full_p1 <= 1'b0;
      else         vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && (!vld_p1 || (pop_p1 && !full_p1))) skid0_p1 <= data_p0;
    else if (pop_p1 && full_p1)                     skid0_p1 <= skid1_p1;
    if (xfer && vld_p1 && !(pop_p1 && !full_p1))    skid1_p1 <= data_p0;
  end
`else
  assign arb_ready = i_ready;
  assign o_valid   = vld_p0;
  assign o_data    = data_p0;
`endif

endmodule

// File: tb/tb_ct_merge_wrr.sv
// Self-checking bench for ct_merge_wrr: directed scenarios plus randomized traffic against a turn-budget model.
module tb_ct_merge_wrr;
  localparam int RADIX = 4;
  localparam int WIDTH = 32;
  localparam int EOP_LOC = 0;
  localparam int WBITS = 4;
  localparam int EXP3[13] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 3, 0, 0, 0};

  logic                   clk = 1'b0;
  logic                   reset;
  logic [RADIX*WIDTH-1:0] i_data;
  logic [RADIX-1:0]       i_valid;
  logic [RADIX-1:0]       o_ready;
  logic [RADIX*WBITS-1:0] i_weight;
  logic [WIDTH-1:0]       o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [1:0]             o_sel;

  ct_merge_wrr #(.RADIX(RADIX), .WIDTH(WIDTH), .EOP_LOC(EOP_LOC), .WBITS(WBITS)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_weight(i_weight), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_sel(o_sel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-input source queues
  logic [31:0] mem [RADIX][1024];
  int          head [RADIX];
  int          tail [RADIX];
  logic [3:0]  bub;
  logic [3:0]  acc;
  int          w [RADIX];
  int          pid = 0;

  function automatic logic [31:0] mk(input int g, input int p, input int b, input bit e);
    return {g[3:0], p[7:0], b[7:0], 11'h0, e};
  endfunction

  task automatic push_pkt(input int g, input int len, input int p);
    for (int b = 0; b < len; b++) begin
      mem[g][tail[g] % 1024] = mk(g, p, b, b == len - 1);
      tail[g]++;
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int g = 0; g < RADIX; g++) s += tail[g] - head[g];
    return s;
  endfunction

  task automatic apply();
    for (int g = 0; g < RADIX; g++) begin
      i_valid[g] = (head[g] != tail[g]) && !bub[g];
      i_data[g*WIDTH +: WIDTH] = (head[g] != tail[g]) ? mem[g][head[g] % 1024] : 32'h0;
      i_weight[g*WBITS +: WBITS] = w[g][3:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int g = 0; g < RADIX; g++) if (acc[g]) head[g]++;
    apply();
  endtask

  task automatic clear_q();
    for (int g = 0; g < RADIX; g++) head[g] = tail[g];
    bub = '0;
    apply();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    i_ready = 1'b1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (pending() != 0 && n < max) begin
      step();
      n++;
    end
    check("drain_left", pending(), 0);
  endtask

  // Model: cur, packet lock, and packets left in the current turn (0 = exhausted)
  int          m_cur = 0;
  bit          m_locked = 0;
  int          m_left = 0;
  bit          m_ok = 0;
  logic [31:0] olog [4096];
  int          on = 0;

  always @(negedge clk) begin
    int          post;
    int          win;
    bit          fnd;
    bit          v;
    bit          x;
    bit          e;
    logic [31:0] d;
    acc = i_valid & o_ready;
    if (m_ok) begin
      check("o_sel", 32'(o_sel), m_cur);
      check("o_valid", 32'(o_valid), 32'(i_valid[m_cur]));
      if (i_valid[m_cur]) check("o_data", o_data, i_data[m_cur*WIDTH +: WIDTH]);
      check("o_ready", 32'(o_ready), i_ready ? (32'h1 << m_cur) : 32'h0);
    end
    if (o_valid && i_ready && on < 4096) begin
      olog[on] = o_data;
      on++;
    end
    if (reset) begin
      m_cur = 0;
      m_locked = 0;
      m_left = 0;
      m_ok = 1;
    end else if (m_ok) begin
      v = i_valid[m_cur];
      d = i_data[m_cur*WIDTH +: WIDTH];
      x = v && i_ready;
      e = x && d[EOP_LOC];
      post = (e && m_left > 0) ? m_left - 1 : m_left;
      m_left = post;
      if (m_locked) begin
        if (e) m_locked = 0;
      end else if (x && !d[EOP_LOC]) begin
        m_locked = 1;
      end else if (!(v && post > 0)) begin
        fnd = 0;
        win = m_cur;
        for (int k = 1; k <= RADIX; k++) begin
          if (!fnd && i_valid[(m_cur + k) % RADIX]) begin
            fnd = 1;
            win = (m_cur + k) % RADIX;
          end
        end
        if (fnd && (win != m_cur || post == 0)) begin
          m_cur = win;
          m_left = int'(i_weight[win*WBITS +: WBITS]) + 1;
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    i_ready = 1'b0;
    bub = '0;
    for (int g = 0; g < RADIX; g++) begin
      head[g] = 0;
      tail[g] = 0;
      w[g] = 0;
    end
    apply();

    // Reset state, then input 2 alone with a 3-beat packet
    push_pkt(2, 3, 1);
    do_reset();
    base = on;
    @(negedge clk);
    check("rst_sel", 32'(o_sel), 0);
    check("rst_valid", 32'(o_valid), 0);
    step();
    @(negedge clk);
    check("t1_sel_c2", 32'(o_sel), 2);
    check("t1_first", o_data, 32'h20100000);
    drain(20);
    check("t1_count", on - base, 3);
    check("t1_b0", olog[base], 32'h20100000);
    check("t1_b1", olog[base + 1], 32'h20101000);
    check("t1_b2", olog[base + 2], 32'h20102001);

    // Weights 0, all inputs single-beat: pure packet round-robin
    clear_q();
    for (int g = 0; g < RADIX; g++) for (int p = 0; p < 4; p++) push_pkt(g, 1, 2);
    do_reset();
    base = on;
    drain(60);
    check("t2_count", on - base, 16);
    for (int i = 0; i < 16; i++) check("t2_src", 32'(olog[base + i][31:28]), i % 4);

    // Weights {2,0,0,0}: input 0 takes three packets per turn
    clear_q();
    w[0] = 2;
    for (int g = 0; g < RADIX; g++) for (int p = 0; p < 10; p++) push_pkt(g, 1, 3);
    do_reset();
    base = on;
    drain(100);
    for (int i = 0; i < 13; i++) check("t3_src", 32'(olog[base + i][31:28]), EXP3[i]);
    w[0] = 0;

    // Input 1 bubbles mid-packet while input 3 waits
    clear_q();
    push_pkt(1, 4, 4);
    push_pkt(3, 1, 4);
    do_reset();
    base = on;
    step();
    step();
    bub[1] = 1'b1;
    step();
    @(negedge clk);
    check("t4_bub_sel", 32'(o_sel), 1);
    check("t4_bub_valid", 32'(o_valid), 0);
    step();
    bub[1] = 1'b0;
    step();
    drain(30);
    check("t4_b0", olog[base], 32'h10400000);
    check("t4_b1", olog[base + 1], 32'h10401000);
    check("t4_b2", olog[base + 2], 32'h10402000);
    check("t4_b3", olog[base + 3], 32'h10403001);
    check("t4_in3", olog[base + 4], 32'h30400001);

    // Downstream stall mid-packet
    clear_q();
    push_pkt(0, 4, 5);
    do_reset();
    base = on;
    step();
    step();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("t5_stall_sel", 32'(o_sel), 0);
      check("t5_stall_data", o_data, 32'h00502000);
    end
    i_ready = 1'b1;
    drain(20);
    check("t5_count", on - base, 4);
    check("t5_b2", olog[base + 2], 32'h00502000);
    check("t5_b3", olog[base + 3], 32'h00503001);

    // Reset during beat 2 of a packet on input 3
    clear_q();
    push_pkt(3, 3, 6);
    do_reset();
    step();
    step();
    reset = 1'b1;
    push_pkt(0, 1, 6);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t6_sel", 32'(o_sel), 0);
    check("t6_valid", 32'(o_valid), 1);
    check("t6_data", o_data, 32'h00600001);
    drain(20);

    // Randomized traffic, weights, bubbles, back-pressure and occasional reset
    clear_q();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < RADIX; g++) begin
        if (tail[g] - head[g] < 8 && $urandom_range(0, 3) == 0) begin
          pid++;
          push_pkt(g, $urandom_range(1, 4), pid);
        end
        bub[g] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 49) == 0) w[g] = $urandom_range(0, 3);
      end
      i_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    i_ready = 1'b1;
    bub = '0;
    drain(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
